ifu_fetch: RTL and testbench

Instruction fetch unit: owns the program counter, fetches instruction words from instruction memory over a request/acknowledge handshake, and presents each word to the control decoder and datapath. It consumes the decoder's `nPC_sel` and the ALU `zero` flag to select the next PC for sequential, beq, j/jal and jr flow. Each instruction is held stable until the datapath signals completion.

---
 rtl/ifu_fetch_if.sv | 30 +++
 rtl/ifu_fetch.sv | 101 ++++++++++
 tb/tb_ifu_fetch.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: next-PC controls in, imem request/response, held instruction out.
// Latency: pure wiring, no state.
// Backpressure: imem_ack is the memory response strobe; advance releases the held word.
interface ifu_fetch_if;
  logic [1:0]  nPC_sel;
  logic        zero;
  logic [31:0] jr_target;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  // Fetch unit side
  modport master (
    input  nPC_sel, zero, jr_target, advance, imem_rdata, imem_ack,
    output imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4, addr_err
  );

  // Memory / decoder / datapath side
  modport slave (
    output nPC_sel, zero, jr_target, advance, imem_rdata, imem_ack,
    input  imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4, addr_err
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, fetches words from imem, holds each for the datapath.
// Latency: 1 cycle from ack to instr_valid; 2 cycles per instruction minimum.
// Backpressure: request held until imem_ack; instruction held until advance.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic         clk,
  input logic         reset,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;
  logic        err_q;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] npc;
  logic        jr_bad;

  // Next-PC selection from the held instruction and decoder controls
  always_comb begin
    pc4    = pc_q + 32'd4;
    br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    npc    = pc4;
    jr_bad = 1'b0;
    case (bus.nPC_sel)
      2'b01:   npc = {pc4[31:28], instr_q[25:0], 2'b00};
      2'b10:   npc = bus.zero ? (pc4 + br_off) : pc4;
      2'b11: begin
        npc    = bus.jr_target;
        jr_bad = |bus.jr_target[1:0];
      end
      default: npc = pc4;
    endcase
  end

  // Fetch FSM with registered request, instruction, valid and error outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.advance) begin
            valid_q <= 1'b0;
            if (jr_bad) begin
              // Misaligned jr: keep the faulting PC visible and stop fetching
              err_q <= 1'b1;
              state <= HALT;
            end else begin
              pc_q  <= npc;
              req_q <= 1'b1;
              state <= FETCH;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.addr_err    = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: hand-computed PCs and handshake timing.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Summary line reports total comparisons and failures.
module tb_ifu_fetch;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, then answer it with a zero-wait ack
  task automatic do_fetch(input logic [31:0] word);
    for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
    check("req_seen", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack   = 1'b0;
  endtask

  // Release the held instruction with the given next-PC controls
  task automatic do_advance(input logic [1:0] sel, input logic z, input logic [31:0] jt);
    bus.nPC_sel   = sel;
    bus.zero      = z;
    bus.jr_target = jt;
    bus.advance   = 1'b1;
    tick();
    bus.advance   = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.nPC_sel    = 2'b00;
    bus.zero       = 1'b0;
    bus.jr_target  = 32'd0;
    bus.advance    = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    tick();
    tick();

    // Reset values
    check("rst_pc",    bus.pc, 32'h0000_3000);
    check("rst_instr", bus.instruction, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    check("rst_err",   {31'd0, bus.addr_err}, 32'd0);

    // BOOT, then request one cycle later
    reset = 1'b0;
    check("boot_req",  {31'd0, bus.imem_req}, 32'd0);
    tick();
    check("first_req", {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h0000_3000);

    // Zero-wait response
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h3421_0005;
    tick();
    bus.imem_ack   = 1'b0;
    check("zw_instr", bus.instruction, 32'h3421_0005);
    check("zw_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("zw_pc",    bus.pc, 32'h0000_3000);
    check("zw_pc4",   bus.pc_plus4, 32'h0000_3004);
    check("zw_req",   {31'd0, bus.imem_req}, 32'd0);

    // Sequential
    do_advance(2'b00, 1'b0, 32'd0);
    check("seq_addr",  bus.imem_addr, 32'h0000_3004);
    check("seq_valid", {31'd0, bus.instr_valid}, 32'd0);

    // Aligned jr to the beq site, beq taken backwards
    do_fetch(32'h0000_0008);
    do_advance(2'b11, 1'b0, 32'h0000_3010);
    check("jr_addr", bus.imem_addr, 32'h0000_3010);
    do_fetch(32'h1000_FFFC);
    do_advance(2'b10, 1'b1, 32'd0);
    check("beq_taken", bus.imem_addr, 32'h0000_3004);

    // beq not taken
    do_fetch(32'h0000_0008);
    do_advance(2'b11, 1'b0, 32'h0000_3010);
    do_fetch(32'h1000_FFFC);
    do_advance(2'b10, 1'b0, 32'd0);
    check("beq_fall", bus.imem_addr, 32'h0000_3014);

    // j at 0x3020
    do_fetch(32'h0000_0008);
    do_advance(2'b11, 1'b0, 32'h0000_3020);
    do_fetch(32'h0800_0C10);
    do_advance(2'b01, 1'b0, 32'd0);
    check("j_addr", bus.imem_addr, 32'h0000_3040);

    // jal at 0x3020: link value visible while held
    do_fetch(32'h0000_0008);
    do_advance(2'b11, 1'b0, 32'h0000_3020);
    do_fetch(32'h0C00_0C10);
    check("jal_pc4", bus.pc_plus4, 32'h0000_3024);
    do_advance(2'b01, 1'b0, 32'd0);
    check("jal_addr", bus.imem_addr, 32'h0000_3040);

    // Wrap past the top of the address space
    do_fetch(32'h0000_0008);
    do_advance(2'b11, 1'b0, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0000);
    do_advance(2'b00, 1'b0, 32'd0);
    check("wrap_addr", bus.imem_addr, 32'h0000_0000);
    check("wrap_err",  {31'd0, bus.addr_err}, 32'd0);

    // 3-cycle ack delay with a stray advance during FETCH
    bus.advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.advance = 1'b0;
      check("dly_req",   {31'd0, bus.imem_req}, 32'd1);
      check("dly_addr",  bus.imem_addr, 32'h0000_0000);
      check("dly_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h2222_0001;
    tick();
    bus.imem_rdata = 32'hDEAD_BEEF;  // ack left high into HOLD must be ignored
    tick();
    bus.imem_ack   = 1'b0;
    check("dly_instr", bus.instruction, 32'h2222_0001);
    check("dly_hold",  {31'd0, bus.instr_valid}, 32'd1);
    check("dly_hreq",  {31'd0, bus.imem_req}, 32'd0);

    // Aligned jr to 0x3100
    do_advance(2'b00, 1'b0, 32'd0);
    do_fetch(32'h0000_0008);
    do_advance(2'b11, 1'b0, 32'h0000_3100);
    check("jr3100", bus.imem_addr, 32'h0000_3100);

    // Reset while waiting, ack arriving at the same moment
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hAAAA_5555;
    reset          = 1'b1;
    #1;
    check("arst_pc",    bus.pc, 32'h0000_3000);
    check("arst_req",   {31'd0, bus.imem_req}, 32'd0);
    check("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check("arst_instr", bus.instruction, 32'd0);
    reset        = 1'b0;
    bus.imem_ack = 1'b0;
    tick();
    check("arst_refetch", bus.imem_addr, 32'h0000_3000);
    check("arst_rreq",    {31'd0, bus.imem_req}, 32'd1);

    // Misaligned jr -> HALT
    do_fetch(32'h0000_0008);
    do_advance(2'b11, 1'b0, 32'h0000_3102);
    check("halt_err",   {31'd0, bus.addr_err}, 32'd1);
    check("halt_pc",    bus.pc, 32'h0000_3000);
    check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
    bus.advance  = 1'b1;
    bus.imem_ack = 1'b1;
    bus.nPC_sel  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.advance  = 1'b0;
    bus.imem_ack = 1'b0;
    check("halt_pc2",   bus.pc, 32'h0000_3000);
    check("halt_vld2",  {31'd0, bus.instr_valid}, 32'd0);
    reset = 1'b1;
    #1;
    check("halt_clr", {31'd0, bus.addr_err}, 32'd0);
    reset = 1'b0;
    tick();
    check("halt_exit", {31'd0, bus.imem_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
